// File: rtl/memory_bus_master_pkg.sv
// Shared types and constants for the main-memory bus initiator.
package memory_bus_master_pkg;

  localparam int         DATAWIDTH_BUS_DEFAULT = 32;
  localparam logic [1:0] ALIGN_MASK            = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DONE  = 2'b10,
    ERROR = 2'b11
  } bus_state_e;

endpackage

// File: rtl/memory_bus_timeout.sv
// Wait-cycle counter for the bus initiator: clears outside the access and flags the last allowed cycle.
module memory_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && !tc)   cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_bus_master.sv
// Single-word main-memory bus initiator with alignment check and bounded ACK wait.
module memory_bus_master
  import memory_bus_master_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DATAWIDTH_BUS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     MEMORY_BUS_MASTER_CLOCK_50,
  input  logic                     MEMORY_BUS_MASTER_RESET_InHigh,
  input  logic                     MEMORY_BUS_MASTER_REQ_In,
  input  logic                     MEMORY_BUS_MASTER_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_data_OutBUS,
  output logic                     MEMORY_BUS_MASTER_BUSY,
  output logic                     MEMORY_BUS_MASTER_DONE,
  output logic                     MEMORY_BUS_MASTER_ERR,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_OutBUS,
  output logic                     MEMORY_BUS_MASTER_MEM_RD_Out,
  output logic                     MEMORY_BUS_MASTER_MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_InBUS,
  input  logic                     MEMORY_BUS_MASTER_MEM_ACK_In
);

  logic clk, rst;
  assign clk = MEMORY_BUS_MASTER_CLOCK_50;
  assign rst = MEMORY_BUS_MASTER_RESET_InHigh;

  bus_state_e               state;
  logic                     busy_q, done_q, err_q, rd_q, wr_q;
  logic [DATAWIDTH_BUS-1:0] addr_q, wdata_q, rdata_q;
  logic                     tc;

  memory_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (state != WAIT),
    .en  (state == WAIT),
    .tc  (tc)
  );

  // Outputs are flopped alongside the state so each one is a clean register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (MEMORY_BUS_MASTER_REQ_In) begin
          busy_q <= 1'b1;
          // A rejected request never reaches the bus, so the bus-side address/data keep their old values.
          if ((MEMORY_BUS_MASTER_ADDRESS_InBUS[1:0] & ALIGN_MASK) != 2'b00) begin
            state  <= ERROR;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state   <= WAIT;
            addr_q  <= MEMORY_BUS_MASTER_ADDRESS_InBUS;
            wdata_q <= MEMORY_BUS_MASTER_data_InBUS;
            rd_q    <= !MEMORY_BUS_MASTER_WR_In;
            wr_q    <= MEMORY_BUS_MASTER_WR_In;
          end
        end
        WAIT: begin
          if (MEMORY_BUS_MASTER_MEM_ACK_In) begin
            if (rd_q) rdata_q <= MEMORY_BUS_MASTER_MEM_data_InBUS;
            state  <= DONE;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b1;
          end else if (tc) begin
            state  <= ERROR;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        DONE, ERROR: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MEMORY_BUS_MASTER_data_OutBUS        = rdata_q;
  assign MEMORY_BUS_MASTER_BUSY               = busy_q;
  assign MEMORY_BUS_MASTER_DONE               = done_q;
  assign MEMORY_BUS_MASTER_ERR                = err_q;
  assign MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS = addr_q;
  assign MEMORY_BUS_MASTER_MEM_data_OutBUS    = wdata_q;
  assign MEMORY_BUS_MASTER_MEM_RD_Out         = rd_q;
  assign MEMORY_BUS_MASTER_MEM_WR_Out         = wr_q;

endmodule
